// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong scheduler in front of frame_buffer: the writer fills the back region while the
// display scans the front region; regions swap only at a reader frame boundary once a
// complete back frame exists.
module fb_pingpong_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned H_RES      = 80,
   parameter int unsigned V_RES      = 64
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic                  s_sof_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  rd_req_i,
   output logic                  rd_valid_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_sof_o,
   output logic                  rd_eof_o,
   output logic                  fb_wr_o,
   output logic [ADDR_WIDTH-1:0] fb_addr_wr_o,
   output logic [DATA_WIDTH-1:0] fb_data_o,
   output logic [ADDR_WIDTH-1:0] fb_addr_rd_o,
   input  logic [DATA_WIDTH-1:0] fb_data_i,
   output logic                  front_sel_o,
   output logic                  frame_drop_o
);

   localparam int unsigned FRAME_PIXELS = H_RES * V_RES;
   localparam int unsigned CntW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] Region1Base = ADDR_WIDTH'(FRAME_PIXELS);

   typedef enum logic [1:0] {WIdle, WWrite, WDone} wstate_e;

   wstate_e               wstate_q, wstate_d;
   logic [CntW-1:0]       wcnt_q, wcnt_d;
   logic [CntW-1:0]       rcnt_q, rcnt_d;
   logic                  front_q, front_d;
   logic                  s_ready, accept, rd_last, swap;
   logic                  wr_en, drop;
   logic [CntW-1:0]       wr_off;
   logic [ADDR_WIDTH-1:0] back_base, front_base;

   logic                  fb_wr_q, rd_valid_q, rd_sof_q, rd_eof_q, drop_q;
   logic [ADDR_WIDTH-1:0] fb_addr_wr_q;
   logic [DATA_WIDTH-1:0] fb_data_q;

   // Ready is held low while reset is asserted so the source sees no acceptance then.
   assign s_ready    = ~reset_i & (wstate_q != WDone);
   assign accept     = s_valid_i & s_ready;
   assign rd_last    = (rcnt_q == LastCnt);
   // Only a writer already parked in WDone qualifies; entering it this cycle does not.
   assign swap       = rd_req_i & rd_last & (wstate_q == WDone);
   assign back_base  = front_q ? '0 : Region1Base;
   assign front_base = front_q ? Region1Base : '0;

   // Writer next-state: frame fill, sof restart with drop pulse, backpressure in WDone.
   always_comb begin
      wstate_d = wstate_q;
      wcnt_d   = wcnt_q;
      wr_en    = 1'b0;
      wr_off   = '0;
      drop     = 1'b0;
      unique case (wstate_q)
         WIdle: begin
            if (accept && s_sof_i) begin
               wr_en    = 1'b1;
               wcnt_d   = CntW'(1);
               wstate_d = WWrite;
            end
         end
         WWrite: begin
            if (accept) begin
               wr_en = 1'b1;
               if (s_sof_i) begin
                  wcnt_d = CntW'(1);
                  drop   = 1'b1;
               end else begin
                  wr_off = wcnt_q;
                  if (wcnt_q == LastCnt) begin
                     wcnt_d   = '0;
                     wstate_d = WDone;
                  end else begin
                     wcnt_d = wcnt_q + CntW'(1);
                  end
               end
            end
         end
         WDone: begin
            if (swap) wstate_d = WIdle;
         end
         default: wstate_d = WIdle;
      endcase
   end

   // Reader next-state: scan counter with wrap, region toggle on a qualified swap.
   always_comb begin
      rcnt_d  = rcnt_q;
      front_d = front_q;
      if (rd_req_i) begin
         rcnt_d = rd_last ? '0 : rcnt_q + CntW'(1);
      end
      if (swap) front_d = ~front_q;
   end

   // State and registered frame_buffer / display outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wstate_q     <= WIdle;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         front_q      <= 1'b0;
         fb_wr_q      <= 1'b0;
         fb_addr_wr_q <= '0;
         fb_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_sof_q     <= 1'b0;
         rd_eof_q     <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         wstate_q     <= wstate_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         front_q      <= front_d;
         fb_wr_q      <= wr_en;
         fb_addr_wr_q <= wr_en ? back_base + ADDR_WIDTH'(wr_off) : '0;
         fb_data_q    <= wr_en ? s_data_i : '0;
         rd_valid_q   <= rd_req_i;
         rd_sof_q     <= rd_req_i & (rcnt_q == '0);
         rd_eof_q     <= rd_req_i & rd_last;
         drop_q       <= drop;
      end
   end

   assign s_ready_o    = s_ready;
   assign fb_wr_o      = fb_wr_q;
   assign fb_addr_wr_o = fb_addr_wr_q;
   assign fb_data_o    = fb_data_q;
   assign fb_addr_rd_o = front_base + ADDR_WIDTH'(rcnt_q);
   assign rd_valid_o   = rd_valid_q;
   assign rd_data_o    = rd_valid_q ? fb_data_i : '0;
   assign rd_sof_o     = rd_sof_q;
   assign rd_eof_o     = rd_eof_q;
   assign front_sel_o  = front_q;
   assign frame_drop_o = drop_q;

endmodule
